mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing one unified memory between the pipeline's instruction-fetch port and data-memory port. It sits between the cpu and a single memory/cache model that uses the busywait handshake. It serialises instruction reads and data loads/stores onto the shared memory and returns per-port busywait and read data. Data has priority on a tie, and the ports alternate when both are pending, so neither starves.

## Interface
- Parameters: none. All addresses and data are fixed at 32 bits.
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  asynchronous, active-high reset
- I_READ  in  1  instruction-fetch read request
- I_ADDR  in  32  fetch address (PC)
- I_READDATA  out  32  fetched instruction (registered)
- I_BUSYWAIT  out  1  fetch stall
- D_READ  in  4  data read control: bit3 = enable, [2:0] = funct3
- D_WRITE  in  3  data write control: bit2 = enable, [1:0] = size
- D_ADDR  in  32  data address
- D_WRITEDATA  in  32  store data
- D_READDATA  out  32  load data (registered)
- D_BUSYWAIT  out  1  data stall
- M_READ  out  4  shared memory read control
- M_WRITE  out  3  shared memory write control
- M_ADDR  out  32  shared memory address
- M_WRITEDATA  out  32  shared memory store data
- M_READDATA  in  32  shared memory read data
- M_BUSYWAIT  in  1  shared memory busy

## Operation
- Request definitions:
  - I_REQ = I_READ.
  - D_REQ = D_READ[3] | D_WRITE[2].
- Requesters hold their request and operands stable until they see their busywait low at a clock edge.
- States: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
- From IDLE:
  - D_REQ goes to SERVE_D.
  - Otherwise, I_REQ goes to SERVE_I.
  - Otherwise, stay in IDLE.
- SERVE_I:
  - Drives M_READ = 4'b1010 (word read), M_WRITE = 0, M_ADDR = I_ADDR.
  - Completion is a cycle with M_BUSYWAIT == 0. On that edge, I_READDATA <= M_READDATA and the state goes to DONE_I.
- SERVE_D:
  - Drives M_READ = D_READ, M_WRITE = D_WRITE, M_ADDR = D_ADDR, M_WRITEDATA = D_WRITEDATA.
  - On completion, if D_READ[3] = 1, D_READDATA <= M_READDATA. A store leaves D_READDATA unchanged. The state goes to DONE_D.
- DONE_X:
  - M_* are idle (all zero).
  - X's request in this cycle is the one that just completed and is ignored.
  - DONE_D goes to SERVE_I if I_REQ, else IDLE.
  - DONE_I goes to SERVE_D if D_REQ, else IDLE.
  - This gives alternation under contention.
- Busywait outputs (combinational):
  - I_BUSYWAIT = I_REQ & (state != DONE_I).
  - D_BUSYWAIT = D_REQ & (state != DONE_D).
- In IDLE and DONE states, M_READ, M_WRITE, M_ADDR and M_WRITEDATA are all 0.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE.
  - I_READDATA = D_READDATA = 0.
  - M_* = 0.
  - Busywaits follow their combinational equations.
  - An aborted memory access is dropped and never retried.
- Minimum latency with a zero-wait memory:
  - Request seen in IDLE at edge t.
  - SERVE at t+1; completion in the same cycle.
  - DONE at t+2, where busywait is low and data is valid.
  - The requester advances at edge t+3, so 3 cycles per access.
- Memory with N busy cycles adds N cycles.
- Simultaneous requests in IDLE: D is served first. I is issued directly from DONE_D with no IDLE cycle.
- A request that drops while in SERVE is a protocol violation. Behaviour is undefined, but the arbiter must still return to IDLE once memory completes.
- M_* change only on clock edges via state. Within SERVE they track the granted port's inputs combinationally, which are stable by protocol.

## Structure
- Package `mem_arbiter_pkg`:
  - 3-bit state encoding: IDLE=0, SERVE_I=1, SERVE_D=2, DONE_I=3, DONE_D=4.
  - Constant FETCH_READ_CTRL = 4'b1010.
- Single flat module: one state register, two readdata registers, and a combinational output mux. No sub-module.

## Test plan
- Fetch only: I_READ=1, I_ADDR=0x40, memory with 2 wait cycles returns 0x00A00093. I_BUSYWAIT stays high until DONE_I, then I_READDATA=0x00A00093 and I_BUSYWAIT=0 for exactly one cycle. Total 5 cycles.
- Store only: D_WRITE=3'b110, D_ADDR=0x100, D_WRITEDATA=0xDEADBEEF. M_WRITE=3'b110, M_ADDR=0x100, M_WRITEDATA=0xDEADBEEF during SERVE_D. D_READDATA is unchanged (0 after reset).
- Contention: both request in IDLE, D is a load from 0x200 returning 0x12345678, zero-wait memory.
  - D is served first and D_READDATA=0x12345678.
  - SERVE_I follows DONE_D immediately.
  - I_BUSYWAIT stays high throughout D's service.
- Back-to-back alternation: both ports continuously re-request. Grant sequence is D, I, D, I with no IDLE cycles between them.
- Reset mid-transaction: assert RESET in SERVE_D while M_BUSYWAIT=1.
  - state=IDLE, M_READ=M_WRITE=0, D_READDATA=0 immediately, without waiting for a clock edge.
  - After release, a held D_REQ is re-arbitrated from IDLE.
- Idle: no requests for 10 cycles. All M_* stay 0 and both busywaits stay 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } arb_state_t;

  // Word read with the enable bit set, as issued for every instruction fetch.
  localparam logic [3:0] FETCH_READ_CTRL = 4'b1010;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one busywait memory.
// Data wins ties; the DONE states hand the grant to the other port so neither starves.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ,
  input  logic [31:0] I_ADDR,
  output logic [31:0] I_READDATA,
  output logic        I_BUSYWAIT,
  input  logic [3:0]  D_READ,
  input  logic [2:0]  D_WRITE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WRITEDATA,
  output logic [31:0] D_READDATA,
  output logic        D_BUSYWAIT,
  output logic [3:0]  M_READ,
  output logic [2:0]  M_WRITE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WRITEDATA,
  input  logic [31:0] M_READDATA,
  input  logic        M_BUSYWAIT
);

  arb_state_t state, next_state;
  logic       i_req, d_req, mem_done;

  assign i_req    = I_READ;
  assign d_req    = D_READ[3] | D_WRITE[2];
  assign mem_done = ~M_BUSYWAIT;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Read data is captured on the completing edge so it is valid during DONE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      I_READDATA <= '0;
      D_READDATA <= '0;
    end else begin
      if (state == SERVE_I && mem_done)
        I_READDATA <= M_READDATA;
      if (state == SERVE_D && mem_done && D_READ[3])
        D_READDATA <= M_READDATA;
    end
  end

  always_comb begin
    next_state  = state;
    M_READ      = '0;
    M_WRITE     = '0;
    M_ADDR      = '0;
    M_WRITEDATA = '0;
    case (state)
      IDLE: begin
        if (d_req)      next_state = SERVE_D;
        else if (i_req) next_state = SERVE_I;
      end
      SERVE_I: begin
        M_READ = FETCH_READ_CTRL;
        M_ADDR = I_ADDR;
        if (mem_done) next_state = DONE_I;
      end
      SERVE_D: begin
        M_READ      = D_READ;
        M_WRITE     = D_WRITE;
        M_ADDR      = D_ADDR;
        M_WRITEDATA = D_WRITEDATA;
        if (mem_done) next_state = DONE_D;
      end
      // The finishing port still shows its old request here, so only the other port is considered.
      DONE_I:  next_state = d_req ? SERVE_D : IDLE;
      DONE_D:  next_state = i_req ? SERVE_I : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign I_BUSYWAIT = i_req & (state != DONE_I);
  assign D_BUSYWAIT = d_req & (state != DONE_D);

endmodule
